axi_line_master: RTL and testbench

Single-outstanding AXI4 master that performs 128-bit cache-line writebacks and refills for the data-cache miss path. Sits between the data cache controller and the top-level `M_AXI_*` DRAM port. Accepts one request at a time, optionally evict-then-refill. Returns the refilled line with a one-cycle completion pulse.

---
 rtl/axi_line_master.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_axi_line_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// axi_line_master: single-outstanding AXI4 master for data-cache line
// writebacks and refills. One request is accepted at a time. The request
// performs an optional writeback (AW+W+B), then an optional refill (AR+R),
// and ends with a one-cycle resp_valid pulse. One line is one beat.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req_*                 miss request (valid/ready handshake, wb/rf flags,
//                         write/read line addresses, evicted line data)
//   resp_valid            one-cycle completion pulse
//   resp_rdata            last refilled line, held until the next refill
//   err                   sticky AXI error flag
//   M_AXI_AW/W/B/AR/R*    AXI4 master channels (single-beat INCR bursts)
//
// Build option: define AXI_ERR_STICKY_EN to make err track non-OKAY
// BRESP/RRESP; otherwise err is tied to 0.
module axi_line_master #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic                  req_rf,
  input  logic [ADDR_W-1:0]     req_waddr,
  input  logic [ADDR_W-1:0]     req_raddr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  err,

  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWLOCK,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic [3:0]            M_AXI_AWQOS,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic [1:0]            M_AXI_ARLOCK,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic [3:0]            M_AXI_ARQOS,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFS_W  = $clog2(STRB_W);
  localparam int unsigned LINE_W = ADDR_W - OFS_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rf_q, rf_d;
  logic [LINE_W-1:0]   waddr_q, waddr_d;
  logic [LINE_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rf_q         <= 1'b0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rf_q         <= rf_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next state; every output flop is loaded with its value for the next
  // state so that handshake signals appear in the cycle the state is entered.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = 1'b0;
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    rf_d         = rf_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          rf_d        = req_rf;
          waddr_d     = req_waddr[ADDR_W-1:OFS_W];
          raddr_d     = req_raddr[ADDR_W-1:OFS_W];
          wdata_d     = req_wdata;
          if (req_wb) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else if (req_rf) begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end else begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
          end
        end
      end

      // AW and W retire independently; leave once both have handshaken.
      S_WADDR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end

      // AR is only issued after B so a refill of the evicted line sees it.
      S_WRESP: begin
        bready_d = 1'b1;
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (rf_q) begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end else begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
          end
        end
      end

      S_RADDR: begin
        arvalid_d = 1'b1;
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
          rready_d  = 1'b1;
        end
      end

      S_RDATA: begin
        rready_d = 1'b1;
        if (M_AXI_RVALID) begin
          rready_d     = 1'b0;
          rdata_d      = M_AXI_RDATA;
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
      end
    endcase
  end

`ifdef AXI_ERR_STICKY_EN
  logic err_q, err_d;

  // Sticky error: any non-OKAY B or R response seen during a handshake
  always_comb begin
    err_d = err_q;
    if ((state_q == S_WRESP) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00)) err_d = 1'b1;
    if ((state_q == S_RDATA) && M_AXI_RVALID && (M_AXI_RRESP != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, M_AXI_RLAST, req_waddr[OFS_W-1:0], req_raddr[OFS_W-1:0]};
`else
  assign err = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, M_AXI_RLAST, M_AXI_BRESP, M_AXI_RRESP,
                       req_waddr[OFS_W-1:0], req_raddr[OFS_W-1:0]};
`endif

  // Request-side outputs
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

  // Write channels: line-aligned single-beat INCR, full strobes
  assign M_AXI_AWADDR  = {waddr_q, {OFS_W{1'b0}}};
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b100;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {STRB_W{1'b1}};
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

  // Read channels
  assign M_AXI_ARADDR  = {raddr_q, {OFS_W{1'b0}}};
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b100;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_line_master.sv
`timescale 1ns/1ps
module tb_axi_line_master;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;
`ifdef AXI_ERR_STICKY_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [DATA_W-1:0] D1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [DATA_W-1:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DATA_W-1:0] W2 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [DATA_W-1:0] W3 = 128'hCAFE_F00D_0000_0001_8000_0000_7777_1234;
  localparam logic [DATA_W-1:0] W4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_wb, req_rf;
  logic [ADDR_W-1:0] req_waddr, req_raddr;
  logic [DATA_W-1:0] req_wdata, resp_rdata;
  logic resp_valid, err;

  logic [ADDR_W-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [7:0] M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0] M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0] M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_AWLOCK;
  logic [3:0] M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
  logic [DATA_W-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  axi_line_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_rf(req_rf),
    .req_waddr(req_waddr), .req_raddr(req_raddr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err(err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                due;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Slave configuration and expected channel contents, written by the sequencer
  int aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [ADDR_W-1:0] exp_awaddr = '0, exp_araddr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;

  // Activity counters, written only by the monitor
  int aw_hi = 0, w_hi = 0, v_hi = 0;

  logic [DATA_W-1:0] mem [256];

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // AXI slave: programmable delays, line memory indexed by addr[11:4]
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok, ar_ok, wb_open;
    int aw_cnt, w_cnt, b_cnt, r_cnt;
    logic [ADDR_W-1:0] aw_addr_l, ar_addr_l;
    logic [DATA_W-1:0] w_data_l;
    logic [7:0] idx;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h23] = D1;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok, ar_ok, wb_open} = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_addr_l = '0; ar_addr_l = '0; w_data_l = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0; M_AXI_RDATA = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok, ar_ok, wb_open} = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
        M_AXI_RVALID = 0; M_AXI_RLAST = 0;
      end else begin
        // retire handshakes that completed on the previous rising edge
        if (b_hs) begin aw_ok = 0; w_ok = 0; wb_open = 0; b_cnt = 0; end
        if (aw_hs) aw_ok = 1;
        if (w_hs) w_ok = 1;
        if (r_hs) begin ar_ok = 0; r_cnt = 0; end
        if (ar_hs) ar_ok = 1;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        if (M_AXI_AWVALID || M_AXI_WVALID) wb_open = 1;

        M_AXI_AWREADY = 0;
        if (M_AXI_AWVALID && !aw_ok) begin
          if (aw_cnt >= aw_delay) begin
            M_AXI_AWREADY = 1; aw_hs = 1; aw_cnt = 0; aw_addr_l = M_AXI_AWADDR;
            check("awaddr", DATA_W'(M_AXI_AWADDR), DATA_W'(exp_awaddr));
            check("aw_attr", DATA_W'({M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
                                      M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS}),
                  DATA_W'({8'd0, 3'b100, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
          end else aw_cnt++;
        end

        M_AXI_WREADY = 0;
        if (M_AXI_WVALID && !w_ok) begin
          if (w_cnt >= w_delay) begin
            M_AXI_WREADY = 1; w_hs = 1; w_cnt = 0; w_data_l = M_AXI_WDATA;
            check("wdata", M_AXI_WDATA, exp_wdata);
            check("w_attr", DATA_W'({M_AXI_WSTRB, M_AXI_WLAST}), DATA_W'({16'hFFFF, 1'b1}));
          end else w_cnt++;
        end

        M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        if (aw_ok && w_ok) begin
          idx = aw_addr_l[11:4];
          mem[idx] = w_data_l;
          if (b_cnt >= b_delay) begin
            M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg; b_hs = M_AXI_BREADY;
          end else b_cnt++;
        end

        M_AXI_ARREADY = 0;
        if (M_AXI_ARVALID && !ar_ok) begin
          M_AXI_ARREADY = 1; ar_hs = 1; ar_addr_l = M_AXI_ARADDR;
          check("araddr", DATA_W'(M_AXI_ARADDR), DATA_W'(exp_araddr));
          check("ar_attr", DATA_W'({M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
                                    M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS}),
                DATA_W'({8'd0, 3'b100, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0}));
          check("ar_after_b", DATA_W'(wb_open), DATA_W'(1'b0));
        end

        M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
        if (ar_ok) begin
          if (r_cnt >= r_delay) begin
            idx = ar_addr_l[11:4];
            M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RRESP = rresp_cfg;
            M_AXI_RDATA = mem[idx]; r_hs = M_AXI_RREADY;
          end else r_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every resp_valid and checks the response
  initial begin
    bit ready_due;
    exp_t e;
    ready_due = 0;
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID) aw_hi++;
      if (M_AXI_WVALID) w_hi++;
      if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID) v_hi++;
      if (ready_due) begin
        check("ready_after_resp", DATA_W'(req_ready), DATA_W'(1'b1));
        ready_due = 0;
      end
      if (rst && resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", DATA_W'(err), DATA_W'(e.err));
          check("resp_cycle", DATA_W'(cyc), DATA_W'(e.due));
        end
        ready_due = 1;
      end
    end
  end

  task automatic issue(input bit wb, input bit rf, input logic [ADDR_W-1:0] wa,
                       input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] exp_rd, input int lat, input logic exp_err,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("req_ready_wait", DATA_W'(req_ready), DATA_W'(1'b1));
    exp_awaddr = {wa[ADDR_W-1:4], 4'h0};
    exp_araddr = {ra[ADDR_W-1:4], 4'h0};
    exp_wdata  = wd;
    req_valid = 1; req_wb = wb; req_rf = rf;
    req_waddr = wa; req_raddr = ra; req_wdata = wd;
    if (push) begin
      e.rdata = exp_rd; e.err = exp_err; e.due = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    // scramble request fields; the DUT must use its registered copy
    req_valid = 0; req_wb = 1; req_rf = 1;
    req_waddr = '1; req_raddr = '1; req_wdata = '1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, DATA_W'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                     M_AXI_ARVALID, M_AXI_RREADY, resp_valid}), '0);
    check({tag, "_req_ready"}, DATA_W'(req_ready), DATA_W'(1'b1));
    check({tag, "_rdata"}, resp_rdata, '0);
    check({tag, "_err"}, DATA_W'(err), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, v0, n;
    rst = 0;
    req_valid = 0; req_wb = 0; req_rf = 0;
    req_waddr = '0; req_raddr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1;
    @(negedge clk);

    // refill only, unaligned address, zero-wait slave
    issue(0, 1, '0, 27'h000_1237, '0, D1, 3, 1'b0, 1);
    drain(50);

    // writeback + refill same line, AWREADY delayed 3 cycles
    aw_delay = 3;
    a0 = aw_hi; w0 = w_hi;
    issue(1, 1, 27'h40, 27'h40, W1, W1, 8, 1'b0, 1);
    drain(50);
    check("awvalid_cycles", DATA_W'(aw_hi - a0), DATA_W'(4));
    check("wvalid_cycles", DATA_W'(w_hi - w0), DATA_W'(1));
    aw_delay = 0;

    // writeback only, BVALID delayed 5 cycles; resp_rdata keeps prior line
    b_delay = 5;
    issue(1, 0, 27'h80, '0, W2, W1, 8, 1'b0, 1);
    drain(50);
    b_delay = 0;

    // empty request
    v0 = v_hi;
    issue(0, 0, 27'h300, 27'h300, W4, W1, 1, 1'b0, 1);
    drain(50);
    check("empty_no_axi", DATA_W'(v_hi - v0), '0);

    // writeback + refill of different lines, zero-wait
    issue(1, 1, 27'h100, 27'h85, W3, W2, 5, 1'b0, 1);
    drain(50);

    // reset while waiting in RDATA
    r_delay = 50;
    issue(0, 1, '0, 27'h40, '0, '0, 0, 1'b0, 0);
    n = 0;
    while (!M_AXI_RREADY && n < 20) begin @(negedge clk); n++; end
    check("in_rdata", DATA_W'(M_AXI_RREADY), DATA_W'(1'b1));
    rst = 0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    r_delay = 0;
    @(negedge clk);
    check("ready_after_rst", DATA_W'(req_ready), DATA_W'(1'b1));
    issue(0, 1, '0, 27'h100, '0, W3, 3, 1'b0, 1);
    drain(50);

    // back-to-back refills
    issue(0, 1, '0, 27'h40, '0, W1, 3, 1'b0, 1);
    issue(0, 1, '0, 27'h8F, '0, W2, 3, 1'b0, 1);
    drain(50);

    // SLVERR on R: sticky when enabled, data still captured
    rresp_cfg = 2'b10;
    issue(0, 1, '0, 27'h1230, '0, D1, 3, ERR_EN, 1);
    drain(50);
    rresp_cfg = 2'b00;
    issue(0, 1, '0, 27'h40, '0, W1, 3, ERR_EN, 1);
    drain(50);
    rst = 0;
    #1;
    check("err_reset", DATA_W'(err), '0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    issue(0, 1, '0, 27'h80, '0, W2, 3, 1'b0, 1);
    drain(50);

    // DECERR on B
    bresp_cfg = 2'b11;
    issue(1, 0, 27'h200, '0, W4, W2, 3, ERR_EN, 1);
    drain(50);
    bresp_cfg = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
